game_referee: RTL and testbench

//  Rally/score controller; the consumer side of the Ball interface. Watches Ball_X/Ball_Y,

---
 rtl/game_referee.sv | 172 +++++++++++++++++
 tb/tb_game_referee.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/game_referee.sv
// ---------------------------------------------------------------------------
// game_referee
//   Rally/score controller that sits beside the Ball block. It watches the
//   ball position, detects ground contact and which side of the net the ball
//   landed on, keeps both scores and drives the game state back to the ball
//   and Pikachu blocks.
//
// Ports
//   clk          in   1   system clock
//   reset_n      in   1   synchronous, active-low reset
//   Ball_X       in   12  ball left edge (px)
//   Ball_Y       in   12  ball top edge (px)
//   start_btn    in   1   start/restart request (level, synchronised to clk)
//   Game_state   out  2   0 START, 1 WAIT, 2 IN_GAME, 3 GAME_END
//   who_win      out  1   0 player won last point, 1 NPC won last point
//   Player_score out  4   player points
//   NPC_score    out  4   NPC points
//   point_pulse  out  1   one-cycle strobe when a point is awarded
//
// Handshake: there is no valid/ready pair here. start_btn is a level whose
// rising edge is the only request; Ball_X/Ball_Y are sampled every cycle and
// only matter in IN_GAME once the guard window has expired.
// ---------------------------------------------------------------------------
module game_referee #(
  parameter int BALL_W       = 30,
  parameter int BALL_H       = 30,
  parameter int GROUND_Y     = 220,
  parameter int NET_X        = 160,
  parameter int NET_W        = 6,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_DELAY  = 100000000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  input  logic        start_btn,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  Player_score,
  output logic [3:0]  NPC_score,
  output logic        point_pulse
);

  localparam int DW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DLY_LAST   = DW'(SERVE_DELAY - 1);
  localparam logic [GW-1:0] GUARD_SAT  = GW'(GUARD_CYCLES);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [12:0]   GROUND_LIM = 13'(GROUND_Y);
  localparam logic [12:0]   NET_CENTER = 13'(NET_X + NET_W / 2);

  typedef enum logic [1:0] {
    ST_START    = 2'd0,
    ST_WAIT     = 2'd1,
    ST_IN_GAME  = 2'd2,
    ST_GAME_END = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [3:0]    p_score_q, p_score_d;
  logic [3:0]    n_score_q, n_score_d;
  logic          who_win_q, who_win_d;
  logic          pulse_q, pulse_d;
  logic          start_prev_q;

  logic          start_edge;
  logic          ground_hit;
  logic          left_half;
  logic [12:0]   ball_bottom;
  logic [12:0]   ball_centre;

  // Widen to 13 bits so positions near the top of the 12-bit range cannot wrap.
  assign ball_bottom = {1'b0, Ball_Y} + 13'(BALL_H);
  assign ball_centre = {1'b0, Ball_X} + 13'(BALL_W / 2);
  assign ground_hit  = (ball_bottom >= GROUND_LIM);
  // A centre exactly on the net centre counts as the right (player) half.
  assign left_half   = (ball_centre < NET_CENTER);
  assign start_edge  = start_btn & ~start_prev_q;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    guard_d   = guard_q;
    p_score_d = p_score_q;
    n_score_d = n_score_q;
    who_win_d = who_win_q;
    pulse_d   = 1'b0;

    unique case (state_q)
      ST_START: begin
        if (start_edge) begin
          state_d   = ST_WAIT;
          p_score_d = '0;
          n_score_d = '0;
          who_win_d = 1'b0;
          dly_d     = '0;
        end
      end

      ST_WAIT: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_IN_GAME;
          guard_d = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      ST_IN_GAME: begin
        if (guard_q != GUARD_SAT) begin
          guard_d = guard_q + 1'b1;
        end else if (ground_hit) begin
          // Leaving IN_GAME right away is what limits a rally to one point.
          pulse_d = 1'b1;
          dly_d   = '0;
          if (left_half) begin
            p_score_d = p_score_q + 1'b1;
            who_win_d = 1'b0;
            state_d   = (p_score_d == WIN) ? ST_GAME_END : ST_WAIT;
          end else begin
            n_score_d = n_score_q + 1'b1;
            who_win_d = 1'b1;
            state_d   = (n_score_d == WIN) ? ST_GAME_END : ST_WAIT;
          end
        end
      end

      ST_GAME_END: begin
        // Scores stay visible until the next START->WAIT transition.
        if (start_edge) begin
          state_d = ST_START;
        end
      end

      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_START;
      dly_q        <= '0;
      guard_q      <= '0;
      p_score_q    <= '0;
      n_score_q    <= '0;
      who_win_q    <= 1'b0;
      pulse_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      guard_q      <= guard_d;
      p_score_q    <= p_score_d;
      n_score_q    <= n_score_d;
      who_win_q    <= who_win_d;
      pulse_q      <= pulse_d;
      start_prev_q <= start_btn;
    end
  end

  assign Game_state   = state_q;
  assign who_win      = who_win_q;
  assign Player_score = p_score_q;
  assign NPC_score    = n_score_q;
  assign point_pulse  = pulse_q;

endmodule

// File: tb/tb_game_referee.sv
// ---------------------------------------------------------------------------
// tb_game_referee
//   Directed bench for game_referee with SERVE_DELAY=10, GUARD_CYCLES=4,
//   WIN_SCORE=2. Inputs change 1 time unit after a rising edge and outputs
//   are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_game_referee;

  logic        clk;
  logic        reset_n;
  logic [11:0] ball_x;
  logic [11:0] ball_y;
  logic        start_btn;
  logic [1:0]  game_state;
  logic        who_win;
  logic [3:0]  player_score;
  logic [3:0]  npc_score;
  logic        point_pulse;

  int n_compared;
  int n_mismatched;

  game_referee #(
    .WIN_SCORE    (2),
    .SERVE_DELAY  (10),
    .GUARD_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .Ball_X       (ball_x),
    .Ball_Y       (ball_y),
    .start_btn    (start_btn),
    .Game_state   (game_state),
    .who_win      (who_win),
    .Player_score (player_score),
    .NPC_score    (npc_score),
    .point_pulse  (point_pulse)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ball(input logic [11:0] x, input logic [11:0] y);
    ball_x = x;
    ball_y = y;
  endtask

  // Advance until Game_state reaches target or the budget runs out.
  task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
    for (int i = 0; i < budget && game_state != target; i++) tick();
    check(tag, game_state, target);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
  endtask

  // From the first IN_GAME cycle: ball on ground, 5 edges to the point.
  task automatic land(input logic [11:0] x, input logic [11:0] y);
    wait_state("reach_in_game", 2'd2, 20);
    set_ball(x, y);
    repeat (5) tick();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset_n      = 1'b0;
    start_btn    = 1'b0;
    set_ball(12'd0, 12'd0);

    // reset
    repeat (3) tick();
    check("rst_state", game_state, 2'd0);
    check("rst_pscore", player_score, 4'd0);
    check("rst_nscore", npc_score, 4'd0);
    check("rst_who_win", who_win, 1'b0);
    check("rst_pulse", point_pulse, 1'b0);
    reset_n = 1'b1;
    tick();
    check("start_idle", game_state, 2'd0);

    // serve: start held high through WAIT must not matter
    start_btn = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) check($sformatf("wait_cyc%0d", k), game_state, 2'd1);
    for (int k = 0; k < 10; k++) if (k < 9) tick();
    // note: the loop above checked the same sample; walk WAIT explicitly
    start_btn = 1'b0;
    tick();
    check("serve_in_game", game_state, 2'd2);

    // guard window: contact during the first 4 IN_GAME cycles is ignored
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    press_start();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("serve_wait%0d", k), game_state, 2'd1);
      tick();
    end
    check("serve_enter", game_state, 2'd2);
    set_ball(12'd100, 12'd190);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("guard_nopulse%0d", k), point_pulse, 1'b0);
      check($sformatf("guard_state%0d", k), game_state, 2'd2);
    end
    check("guard_pscore", player_score, 4'd0);

    // left landing (bottom exactly on ground line)
    tick();
    check("left_pscore", player_score, 4'd1);
    check("left_nscore", npc_score, 4'd0);
    check("left_who_win", who_win, 1'b0);
    check("left_pulse", point_pulse, 1'b1);
    check("left_state", game_state, 2'd1);
    tick();
    check("left_pulse_off", point_pulse, 1'b0);
    check("left_one_point", player_score, 4'd1);
    set_ball(12'd0, 12'd0);

    // right / boundary: centre == net centre, bottom just above ground
    wait_state("right_in_game", 2'd2, 20);
    set_ball(12'd148, 12'd189);
    repeat (7) tick();
    check("above_ground_state", game_state, 2'd2);
    check("above_ground_nscore", npc_score, 4'd0);
    ball_y = 12'd195;
    tick();
    check("right_nscore", npc_score, 4'd1);
    check("right_pscore", player_score, 4'd1);
    check("right_who_win", who_win, 1'b1);
    check("right_pulse", point_pulse, 1'b1);
    check("right_state", game_state, 2'd1);
    set_ball(12'd0, 12'd0);

    // reset mid-rally with ball on ground
    wait_state("mid_in_game", 2'd2, 20);
    set_ball(12'd100, 12'd200);
    reset_n = 1'b0;
    tick();
    check("midrst_state", game_state, 2'd0);
    check("midrst_pscore", player_score, 4'd0);
    check("midrst_nscore", npc_score, 4'd0);
    check("midrst_pulse", point_pulse, 1'b0);
    reset_n = 1'b1;
    set_ball(12'd0, 12'd0);
    tick();

    // game end: two player points with WIN_SCORE=2
    press_start();
    check("g2_wait", game_state, 2'd1);
    land(12'd50, 12'd200);
    check("g2_p1_score", player_score, 4'd1);
    check("g2_p1_state", game_state, 2'd1);
    set_ball(12'd0, 12'd0);
    land(12'd10, 12'd210);
    check("g2_end_state", game_state, 2'd3);
    check("g2_end_pscore", player_score, 4'd2);
    check("g2_end_nscore", npc_score, 4'd0);
    check("g2_end_pulse", point_pulse, 1'b1);
    // frozen while the ball keeps hitting the ground on the other side
    set_ball(12'd200, 12'd210);
    repeat (5) tick();
    check("frozen_state", game_state, 2'd3);
    check("frozen_pscore", player_score, 4'd2);
    check("frozen_nscore", npc_score, 4'd0);
    check("frozen_who_win", who_win, 1'b0);
    // start held high: exactly one transition, scores kept in START
    start_btn = 1'b1;
    tick();
    check("restart_state", game_state, 2'd0);
    repeat (4) tick();
    check("held_state", game_state, 2'd0);
    check("held_pscore", player_score, 4'd2);
    start_btn = 1'b0;
    tick();
    press_start();
    check("new_game_state", game_state, 2'd1);
    check("new_game_pscore", player_score, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
